// File: rtl/nios_input_conditioner_if.sv
// rtl/nios_input_conditioner_if.sv - raw pin and debounced level bundle for the input conditioner
interface nios_input_conditioner_if #(
  parameter int NUM_KEYS = 2,
  parameter int NUM_SW   = 4
);
  logic [NUM_KEYS-1:0] key_n_in;
  logic [NUM_SW-1:0]   sw_in;
  logic [NUM_KEYS-1:0] key_db_n;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_SW-1:0]   sw_db;
  logic                sw_change;

  modport master (
    output key_n_in, sw_in,
    input  key_db_n, key_press, key_release, sw_db, sw_change
  );

  modport slave (
    input  key_n_in, sw_in,
    output key_db_n, key_press, key_release, sw_db, sw_change
  );
endinterface

// File: rtl/nios_input_conditioner.sv
// rtl/nios_input_conditioner.sv - synchronise and debounce pushbuttons and switches for the Nios PIOs
module nios_input_conditioner #(
  parameter int NUM_KEYS            = 2,
  parameter int NUM_SW              = 4,
  parameter int SYNC_STAGES         = 2,
  parameter int KEY_DEBOUNCE_CYCLES = 500000,
  parameter int SW_DEBOUNCE_CYCLES  = 500000
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  nios_input_conditioner_if.slave bus
);
  localparam int NCH = NUM_KEYS + NUM_SW;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] db;
  logic [NCH-1:0] acc;
  logic           sw_change_q;

  // Keys occupy the low channel indices, switches the high ones.
  assign raw = {bus.sw_in, bus.key_n_in};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam bit             IS_KEY = (i < NUM_KEYS);
    localparam int             DC     = IS_KEY ? KEY_DEBOUNCE_CYCLES : SW_DEBOUNCE_CYCLES;
    localparam int             CW     = $clog2(DC + 1);
    localparam logic [CW-1:0]  LAST   = CW'(DC - 1);
    localparam logic           IDLE   = IS_KEY;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   db_q;
    logic                   s;

    assign s      = sync_q[SYNC_STAGES-1];
    assign acc[i] = (s != db_q) && (cnt_q == LAST);
    assign db[i]  = db_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        sync_q <= {SYNC_STAGES{IDLE}};
        cnt_q  <= '0;
        db_q   <= IDLE;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
        if (s == db_q) begin
          cnt_q <= '0;
        end else if (acc[i]) begin
          cnt_q <= '0;
          db_q  <= s;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    if (IS_KEY) begin : g_key
      logic press_q;
      logic release_q;

      // Pulses load on the same edge as db_q so they line up with the new level.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          press_q   <= acc[i] & ~s;
          release_q <= acc[i] & s;
        end
      end

      assign bus.key_press[i]   = press_q;
      assign bus.key_release[i] = release_q;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_change_q <= 1'b0;
    end else begin
      sw_change_q <= |acc[NCH-1:NUM_KEYS];
    end
  end

  assign bus.key_db_n  = db[NUM_KEYS-1:0];
  assign bus.sw_db     = db[NCH-1:NUM_KEYS];
  assign bus.sw_change = sw_change_q;
endmodule

// File: tb/tb_nios_input_conditioner.sv
// tb/tb_nios_input_conditioner.sv - self-checking bench for nios_input_conditioner
module tb_nios_input_conditioner;
  localparam int DC  = 4;
  localparam int NCH = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  nios_input_conditioner_if #(.NUM_KEYS(2), .NUM_SW(4)) bus();

  nios_input_conditioner #(
    .NUM_KEYS(2), .NUM_SW(4), .SYNC_STAGES(2),
    .KEY_DEBOUNCE_CYCLES(DC), .SW_DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: a pin reaches the debouncer two edges late; a channel accepts a new
  // level once its last DC delayed samples all disagree with the accepted level.
  bit   pipe0 [NCH];
  bit   pipe1 [NCH];
  bit   hist  [NCH][$];
  logic [5:0] m_db = 6'b000011;
  logic [1:0] m_press = '0;
  logic [1:0] m_rel = '0;
  logic       m_swc = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [5:0] pins;
    bit all_diff;
    bit smp;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        pipe0[c] = (c < 2);
        pipe1[c] = (c < 2);
        hist[c].delete();
      end
      m_db = 6'b000011; m_press = '0; m_rel = '0; m_swc = 1'b0;
    end else begin
      pins = {bus.sw_in, bus.key_n_in};
      m_press = '0; m_rel = '0; m_swc = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        smp = pipe1[c];
        pipe1[c] = pipe0[c];
        pipe0[c] = pins[c];
        hist[c].push_back(smp);
        if (hist[c].size() > DC) void'(hist[c].pop_front());
        all_diff = (hist[c].size() == DC);
        foreach (hist[c][k]) if (hist[c][k] == m_db[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_db[c] = smp;
          if (c < 2) begin
            if (smp) m_rel[c] = 1'b1; else m_press[c] = 1'b1;
          end else begin
            m_swc = 1'b1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en)
      chk("model", int'({bus.key_db_n, bus.key_press, bus.key_release, bus.sw_db, bus.sw_change}),
          int'({m_db[1:0], m_press, m_rel, m_db[5:2], m_swc}));
  end

  typedef struct {
    logic [1:0] key_n;
    logic [3:0] sw;
    logic [1:0] exp_key;
    logic [3:0] exp_sw;
  } vec_t;

  vec_t vecs[6];
  int   pcount;
  int   pedge;

  initial begin
    vecs[0] = '{2'b11, 4'b0000, 2'b11, 4'b0000};
    vecs[1] = '{2'b01, 4'b1010, 2'b01, 4'b1010};
    vecs[2] = '{2'b10, 4'b1111, 2'b10, 4'b1111};
    vecs[3] = '{2'b00, 4'b0001, 2'b00, 4'b0001};
    vecs[4] = '{2'b11, 4'b1000, 2'b11, 4'b1000};
    vecs[5] = '{2'b11, 4'b0000, 2'b11, 4'b0000};

    // Reset held with random pins.
    bus.key_n_in = 2'b11; bus.sw_in = 4'b0000;
    repeat (5) begin
      bus.key_n_in = 2'($urandom); bus.sw_in = 4'($urandom);
      step();
      chk("rst_key_db", bus.key_db_n, 2'b11);
      chk("rst_sw_db", bus.sw_db, 4'b0000);
      chk("rst_pulses", {bus.key_press, bus.key_release, bus.sw_change}, 0);
    end
    bus.key_n_in = 2'b11; bus.sw_in = 4'b0000;
    step();
    rst_n = 1'b1; chk_en = 1'b1;
    repeat (3) step();

    // Key 0 press latency.
    bus.key_n_in = 2'b10;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("k0_wait_db", bus.key_db_n, 2'b11);
    end
    step();
    chk("k0_db_edge6", bus.key_db_n, 2'b10);
    chk("k0_press_edge6", bus.key_press, 2'b01);
    step();
    chk("k0_press_once", bus.key_press, 2'b00);
    bus.key_n_in = 2'b11;
    repeat (8) step();

    // Short glitch on key 0 is rejected; a following press sees full latency.
    bus.key_n_in = 2'b10;
    repeat (3) step();
    bus.key_n_in = 2'b11;
    for (int e = 0; e < 8; e++) begin
      step();
      chk("glitch_db", bus.key_db_n, 2'b11);
      chk("glitch_press", bus.key_press, 2'b00);
    end
    bus.key_n_in = 2'b10;
    repeat (5) step();
    chk("relatch_wait", bus.key_db_n, 2'b11);
    step();
    chk("relatch_db", bus.key_db_n, 2'b10);
    bus.key_n_in = 2'b11;
    repeat (5) step();
    chk("k0_rel_wait", bus.key_release, 2'b00);
    step();
    chk("k0_release", bus.key_release, 2'b01);
    repeat (3) step();

    // Key 1 bounces every 2 cycles, then settles pressed.
    pcount = 0; pedge = 0;
    for (int t = 0; t < 10; t++) begin
      bus.key_n_in[1] = ~bus.key_n_in[1];
      repeat (2) begin
        step();
        if (bus.key_press[1]) pcount++;
      end
    end
    bus.key_n_in[1] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (bus.key_press[1]) begin pcount++; pedge = e; end
    end
    chk("bounce_press_cnt", pcount, 1);
    chk("bounce_press_edge", pedge, 6);
    pcount = 0;
    bus.key_n_in[1] = 1'b1;
    repeat (10) begin
      step();
      if (bus.key_release[1]) pcount++;
    end
    chk("bounce_release_cnt", pcount, 1);

    // Both keys together.
    bus.key_n_in = 2'b00;
    repeat (5) step();
    chk("both_press_wait", bus.key_press, 2'b00);
    step();
    chk("both_press", bus.key_press, 2'b11);
    repeat (2) step();
    bus.key_n_in = 2'b11;
    repeat (5) step();
    chk("both_rel_wait", bus.key_release, 2'b00);
    step();
    chk("both_release", bus.key_release, 2'b11);
    repeat (2) step();

    // Switches, with reset mid-count.
    bus.sw_in = 4'b0101;
    repeat (5) step();
    chk("sw_wait", bus.sw_db, 4'b0000);
    step();
    chk("sw_db_edge6", bus.sw_db, 4'b0101);
    chk("sw_change", bus.sw_change, 1);
    step();
    chk("sw_change_once", bus.sw_change, 0);
    bus.sw_in = 4'b0111;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk("sw_rst_db", bus.sw_db, 4'b0000);
    chk("sw_rst_change", bus.sw_change, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("sw_requal_wait", bus.sw_db, 4'b0000);
    step();
    chk("sw_requal_db", bus.sw_db, 4'b0111);
    chk("sw_requal_change", bus.sw_change, 1);
    step();

    // Steady-state vector table.
    foreach (vecs[v]) begin
      bus.key_n_in = vecs[v].key_n;
      bus.sw_in    = vecs[v].sw;
      repeat (8) step();
      chk("vec_key_db", bus.key_db_n, vecs[v].exp_key);
      chk("vec_sw_db", bus.sw_db, vecs[v].exp_sw);
    end

    // Random bouncing pins and occasional reset, checked against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) bus.key_n_in[$urandom_range(0, 1)] ^= 1'b1;
        else bus.sw_in[$urandom_range(0, 3)] ^= 1'b1;
      end
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
